// File: rtl/xor_bitwise_stream_if.sv
// Stream bundle for xor_bitwise_stream.
// Input beat, result beat and both handshakes.
interface xor_bitwise_stream_if #(
  parameter int N     = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic [1:0]       in_op;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_f;
  logic             out_par;
  logic [CNT_W-1:0] out_cnt;

  modport master (
    output in_valid, in_a, in_b,
    output in_op, in_last, out_ready,
    input  in_ready, out_valid,
    input  out_f, out_par, out_cnt
  );

  modport slave (
    input  in_valid, in_a, in_b,
    input  in_op, in_last, out_ready,
    output in_ready, out_valid,
    output out_f, out_par, out_cnt
  );
endinterface

// File: rtl/xor_bitwise_stream.sv
// Registered XOR/XNOR/AND/accumulate stage
// with parity and saturating frame counter.
module xor_bitwise_stream #(
  parameter int N     = 16,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  xor_bitwise_stream_if.slave s
);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  state_t           state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     out_f_q, out_f_d;
  logic             out_par_q, out_par_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  logic             accept;
  logic             emit;
  logic [N-1:0]     ab;
  logic [N-1:0]     sum;
  logic [CNT_W-1:0] cnt_inc;
  logic [N-1:0]     f_sel;
  logic [CNT_W-1:0] c_sel;

  assign s.in_ready  = !out_valid_q || s.out_ready;
  assign s.out_valid = out_valid_q;
  assign s.out_f     = out_f_q;
  assign s.out_par   = out_par_q;
  assign s.out_cnt   = out_cnt_q;

  assign accept  = s.in_valid && s.in_ready;
  assign ab      = s.in_a ^ s.in_b;
  assign sum     = acc_q ^ ab;
  assign cnt_inc = (cnt_q == CNT_MAX) ?
                   cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_f_d     = out_f_q;
    out_par_d   = out_par_q;
    out_cnt_d   = out_cnt_q;
    emit        = 1'b0;
    f_sel       = ab;
    c_sel       = CNT_ONE;

    if (s.out_ready) out_valid_d = 1'b0;

    if (accept) begin
      unique case (1'b1)
        (s.in_op == 2'd0): emit = 1'b1;
        (s.in_op == 2'd1): begin
          emit  = 1'b1;
          f_sel = ~ab;
        end
        (s.in_op == 2'd2): begin
          emit  = 1'b1;
          f_sel = s.in_a & s.in_b;
        end
        (s.in_op == 2'd3): begin
          if (state_q == IDLE) begin
            if (s.in_last) begin
              emit = 1'b1;
            end else begin
              acc_d   = ab;
              cnt_d   = CNT_ONE;
              state_d = ACCUM;
            end
          end else if (s.in_last) begin
            emit    = 1'b1;
            f_sel   = sum;
            c_sel   = cnt_inc;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            acc_d = sum;
            cnt_d = cnt_inc;
          end
        end
        default: ;
      endcase
    end

    if (emit) begin
      out_valid_d = 1'b1;
      out_f_d     = f_sel;
      out_par_d   = ^f_sel;
      out_cnt_d   = c_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_f_q     <= '0;
      out_par_q   <= 1'b0;
      out_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_f_q     <= out_f_d;
      out_par_q   <= out_par_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

endmodule
